pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_redir_arb.sv | 46 ++++
 rtl/pipe_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared constants and encodings for the pipeline sequencer and its redirect
// arbiter: boolean/stall levels, the reset PC, the sequencer FSM states and
// the redirect-kind codes.
package pipe_ctrl_pkg;

  localparam logic        TRUE         = 1'b1;
  localparam logic        STALL        = 1'b1;
  localparam logic [31:0] CPU_RST_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_PEND = 2'd2
  } pcState_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_EXC  = 2'd1,
    REDIR_MRET = 2'd2,
    REDIR_BJ   = 2'd3
  } redirKind_e;

  // An exception redirect also flushes MEM and overrides an EX stall.
  function automatic logic isException(input redirKind_e kind);
    return kind == REDIR_EXC;
  endfunction

endpackage

// File: rtl/pipe_ctrl_redir_arb.sv
// redir_arb
// Combinational fixed-priority arbiter for the three PC redirect sources.
// Priority: exception/interrupt (WB) > mret (EX) > branch/jump (EX).
// Ports:
//   exc_req_i/exc_addr_i   : trap request and handler address
//   mret_req_i/mret_addr_i : mret request and mepc
//   bj_req_i/bj_addr_i     : taken branch/jump and its target
//   win_vld_o              : at least one source is requesting
//   win_kind_o             : redirKind_e code of the winner (REDIR_NONE if idle)
//   win_addr_o             : winner's target, zero when idle
module redir_arb
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_addr_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mret_addr_i,
  input  logic            bj_req_i,
  input  logic [XLEN-1:0] bj_addr_i,
  output logic            win_vld_o,
  output logic [1:0]      win_kind_o,
  output logic [XLEN-1:0] win_addr_o
);

  always_comb begin
    win_vld_o  = 1'b0;
    win_kind_o = REDIR_NONE;
    win_addr_o = '0;
    if (exc_req_i) begin
      win_vld_o  = 1'b1;
      win_kind_o = REDIR_EXC;
      win_addr_o = exc_addr_i;
    end else if (mret_req_i) begin
      win_vld_o  = 1'b1;
      win_kind_o = REDIR_MRET;
      win_addr_o = mret_addr_i;
    end else if (bj_req_i) begin
      win_vld_o  = 1'b1;
      win_kind_o = REDIR_BJ;
      win_addr_o = bj_addr_i;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central sequencer for the 5-stage core (IF, ID, EX, MEM, WB). Holds fetch
// off for BOOT_WAIT cycles after reset, arbitrates PC redirects, merges hazard
// and busy sources into per-stage stall/flush controls, holds a redirect that
// the instruction RAM has not yet granted, and counts stalls and redirects.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   iram_gnt_i           : instruction RAM accepts a fetch this cycle
//   exc_req_i/exc_addr_i : WB exception/interrupt and handler address
//   mret_req_i/mret_addr_i, bj_req_i/bj_addr_i : EX redirect sources
//   load_use_i, ex_busy_i, lsu_busy_i : hazard and busy inputs
//   if_valid_o           : fetch enable
//   redirect_vld_o/redirect_addr_o : PC must load redirect_addr_o
//   stall_*_o / flush_*_o : per-stage hold / bubble controls
//   stall_cnt_o          : saturating count of RUN cycles with stall_if_o=1
//   redir_cnt_o          : wrapping count of delivered redirects
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BOOT_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iram_gnt_i,
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_addr_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mret_addr_i,
  input  logic            bj_req_i,
  input  logic [XLEN-1:0] bj_addr_i,
  input  logic            load_use_i,
  input  logic            ex_busy_i,
  input  logic            lsu_busy_i,
  output logic            if_valid_o,
  output logic            redirect_vld_o,
  output logic [XLEN-1:0] redirect_addr_o,
  output logic            stall_if_o,
  output logic            stall_id_o,
  output logic            stall_ex_o,
  output logic            flush_id_o,
  output logic            flush_ex_o,
  output logic            flush_mem_o,
  output logic [31:0]     stall_cnt_o,
  output logic [15:0]     redir_cnt_o
);

  localparam int CW = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;

  pcState_e        state_q, state_d;
  logic [CW-1:0]   bootCnt_q, bootCnt_d;
  logic [XLEN-1:0] pendAddr_q, pendAddr_d;
  redirKind_e      pendKind_q, pendKind_d;
  logic [31:0]     stallCnt_q, stallCnt_d;
  logic [15:0]     redirCnt_q, redirCnt_d;

  logic            winVld;
  logic [1:0]      winKindRaw;
  redirKind_e      winKind;
  logic [XLEN-1:0] winAddr;

  logic            stallExRaw;
  logic            stallIdRaw;
  logic            stallIfRaw;
  logic            redirTake;
  logic            redirInc;
  logic            stallTick;

  redir_arb #(
    .XLEN (XLEN)
  ) u_redir_arb (
    .exc_req_i   (exc_req_i),
    .exc_addr_i  (exc_addr_i),
    .mret_req_i  (mret_req_i),
    .mret_addr_i (mret_addr_i),
    .bj_req_i    (bj_req_i),
    .bj_addr_i   (bj_addr_i),
    .win_vld_o   (winVld),
    .win_kind_o  (winKindRaw),
    .win_addr_o  (winAddr)
  );

  assign winKind    = redirKind_e'(winKindRaw);
  assign stallExRaw = ex_busy_i | lsu_busy_i;
  assign stallIdRaw = stallExRaw | load_use_i;
  assign stallIfRaw = stallIdRaw | ~iram_gnt_i;

  always_comb begin
    state_d         = state_q;
    bootCnt_d       = bootCnt_q;
    pendAddr_d      = pendAddr_q;
    pendKind_d      = pendKind_q;
    if_valid_o      = 1'b0;
    redirect_vld_o  = 1'b0;
    redirect_addr_o = pendAddr_q;
    stall_if_o      = STALL;
    stall_id_o      = STALL;
    stall_ex_o      = STALL;
    flush_id_o      = 1'b0;
    flush_ex_o      = 1'b0;
    flush_mem_o     = 1'b0;
    redirTake       = 1'b0;
    redirInc        = 1'b0;
    stallTick       = 1'b0;

    unique case (state_q)
      PC_BOOT: begin
        if (bootCnt_q == '0) begin
          state_d = PC_RUN;
        end else begin
          bootCnt_d = bootCnt_q - CW'(1);
        end
      end

      PC_RUN: begin
        if_valid_o      = TRUE;
        redirect_addr_o = winAddr;
        stall_ex_o      = stallExRaw;
        stall_id_o      = stallIdRaw;
        stall_if_o      = stallIfRaw;
        flush_ex_o      = load_use_i & ~stallExRaw;
        // An mret/bj whose EX instruction is still held waits until EX moves.
        redirTake = winVld & (isException(winKind) | ~stallExRaw);
        if (redirTake) begin
          stall_if_o  = 1'b0;
          stall_id_o  = 1'b0;
          flush_id_o  = 1'b1;
          flush_ex_o  = 1'b1;
          if (isException(winKind)) begin
            stall_ex_o  = 1'b0;
            flush_mem_o = 1'b1;
          end
          if (iram_gnt_i) begin
            redirect_vld_o = 1'b1;
            redirInc       = 1'b1;
          end else begin
            pendAddr_d = winAddr;
            pendKind_d = winKind;
            state_d    = PC_PEND;
          end
        end
        stallTick = stall_if_o;
      end

      PC_PEND: begin
        if_valid_o     = TRUE;
        redirect_vld_o = 1'b1;
        stall_if_o     = 1'b0;
        stall_id_o     = 1'b0;
        flush_id_o     = 1'b1;
        stall_ex_o     = (isException(pendKind_q) | exc_req_i) ? 1'b0 : stallExRaw;
        flush_ex_o     = exc_req_i | (load_use_i & ~stall_ex_o);
        flush_mem_o    = exc_req_i;
        // A late exception supersedes the held target; the superseded target
        // is not counted and the new one waits for its own grant.
        if (exc_req_i) begin
          pendAddr_d = exc_addr_i;
          pendKind_d = REDIR_EXC;
        end else if (iram_gnt_i) begin
          state_d  = PC_RUN;
          redirInc = 1'b1;
        end
      end

      default: begin
        state_d = PC_BOOT;
      end
    endcase
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    redirCnt_d = redirCnt_q;
    if (stallTick && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
    if (redirInc) begin
      redirCnt_d = redirCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PC_BOOT;
      bootCnt_q  <= CW'(BOOT_WAIT - 1);
      pendAddr_q <= XLEN'(CPU_RST_ADDR);
      pendKind_q <= REDIR_NONE;
      stallCnt_q <= '0;
      redirCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bootCnt_q  <= bootCnt_d;
      pendAddr_q <= pendAddr_d;
      pendKind_q <= pendKind_d;
      stallCnt_q <= stallCnt_d;
      redirCnt_q <= redirCnt_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign redir_cnt_o = redirCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural model of the sequencer.
module tb_pipe_ctrl;

  localparam int XLEN      = 32;
  localparam int BOOT_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iram_gnt;
  logic            exc_req, mret_req, bj_req;
  logic [XLEN-1:0] exc_addr, mret_addr, bj_addr;
  logic            load_use, ex_busy, lsu_busy;
  logic            if_valid, redirect_vld;
  logic [XLEN-1:0] redirect_addr;
  logic            stall_if, stall_id, stall_ex;
  logic            flush_id, flush_ex, flush_mem;
  logic [31:0]     stall_cnt;
  logic [15:0]     redir_cnt;
  logic [7:0]      ctl;

  int tests  = 0;
  int failed = 0;

  // ctl bit order: if_valid, redirect_vld, stall_if, stall_id, stall_ex,
  // flush_id, flush_ex, flush_mem
  assign ctl = {if_valid, redirect_vld, stall_if, stall_id, stall_ex,
                flush_id, flush_ex, flush_mem};

  always #5 clk = ~clk;

  pipe_ctrl #(
    .XLEN      (XLEN),
    .BOOT_WAIT (BOOT_WAIT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .iram_gnt_i      (iram_gnt),
    .exc_req_i       (exc_req),
    .exc_addr_i      (exc_addr),
    .mret_req_i      (mret_req),
    .mret_addr_i     (mret_addr),
    .bj_req_i        (bj_req),
    .bj_addr_i       (bj_addr),
    .load_use_i      (load_use),
    .ex_busy_i       (ex_busy),
    .lsu_busy_i      (lsu_busy),
    .if_valid_o      (if_valid),
    .redirect_vld_o  (redirect_vld),
    .redirect_addr_o (redirect_addr),
    .stall_if_o      (stall_if),
    .stall_id_o      (stall_id),
    .stall_ex_o      (stall_ex),
    .flush_id_o      (flush_id),
    .flush_ex_o      (flush_ex),
    .flush_mem_o     (flush_mem),
    .stall_cnt_o     (stall_cnt),
    .redir_cnt_o     (redir_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    iram_gnt  = 1'b1;
    exc_req   = 1'b0;
    mret_req  = 1'b0;
    bj_req    = 1'b0;
    exc_addr  = '0;
    mret_addr = '0;
    bj_addr   = '0;
    load_use  = 1'b0;
    ex_busy   = 1'b0;
    lsu_busy  = 1'b0;
  endtask

  // Reset, release, and wait until fetch is running with idle inputs.
  task automatic bootReset();
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (BOOT_WAIT) tick();
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if (ctl !== 8'b0011_1000) begin
      failed++;
      $display("[TB] FAIL reset_ctl got %b want %b", ctl, 8'b0011_1000);
    end
    tests++;
    if (redirect_addr !== '0) begin
      failed++;
      $display("[TB] FAIL reset_addr got %h want 0", redirect_addr);
    end
    tests++;
    if (stall_cnt !== 32'd0 || redir_cnt !== 16'd0) begin
      failed++;
      $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, redir_cnt);
    end
  endtask

  task automatic test_boot();
    logic [7:0] want;
    rst_n = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b0011_1000) begin
      failed++;
      $display("[TB] FAIL boot_c0 got %b want %b", ctl, 8'b0011_1000);
    end
    for (int e = 1; e <= BOOT_WAIT + 1; e++) begin
      tick();
      want = (e < BOOT_WAIT) ? 8'b0011_1000 : 8'b1000_0000;
      tests++;
      if (ctl !== want) begin
        failed++;
        $display("[TB] FAIL boot_e%0d got %b want %b", e, ctl, want);
      end
    end
    iram_gnt = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'b1010_0000) begin
      failed++;
      $display("[TB] FAIL boot_nognt got %b want %b", ctl, 8'b1010_0000);
    end
    tick();
    iram_gnt = 1'b1;
    #1;
    tests++;
    if (stall_cnt !== 32'd1 || stall_if !== 1'b0) begin
      failed++;
      $display("[TB] FAIL boot_stallcnt got %0d/%b want 1/0", stall_cnt, stall_if);
    end
  endtask

  task automatic test_branch();
    bootReset();
    bj_req  = 1'b1;
    bj_addr = 32'h80;
    #1;
    tests++;
    if (ctl !== 8'b1100_0110 || redirect_addr !== 32'h80) begin
      failed++;
      $display("[TB] FAIL branch got %b/%h want %b/%h", ctl, redirect_addr, 8'b1100_0110, 32'h80);
    end
    tick();
    bj_req = 1'b0;
    #1;
    tests++;
    if (redir_cnt !== 16'd1 || redirect_vld !== 1'b0) begin
      failed++;
      $display("[TB] FAIL branch_cnt got %0d/%b want 1/0", redir_cnt, redirect_vld);
    end
  endtask

  task automatic test_priority();
    bootReset();
    exc_req = 1'b1; exc_addr  = 32'h100;
    mret_req = 1'b1; mret_addr = 32'h200;
    bj_req = 1'b1; bj_addr = 32'h300;
    lsu_busy = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b1100_0111 || redirect_addr !== 32'h100) begin
      failed++;
      $display("[TB] FAIL prio_exc got %b/%h want %b/%h", ctl, redirect_addr, 8'b1100_0111, 32'h100);
    end
    tick();
    exc_req = 1'b0;
    mret_req = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'b1011_1000) begin
      failed++;
      $display("[TB] FAIL prio_bj_busy got %b want %b", ctl, 8'b1011_1000);
    end
    tick();
    lsu_busy = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'b1100_0110 || redirect_addr !== 32'h300) begin
      failed++;
      $display("[TB] FAIL prio_bj got %b/%h want %b/%h", ctl, redirect_addr, 8'b1100_0110, 32'h300);
    end
    tick();
    bj_req = 1'b0;
    #1;
    tests++;
    if (redir_cnt !== 16'd2 || stall_cnt !== 32'd1) begin
      failed++;
      $display("[TB] FAIL prio_cnt got %0d/%0d want 2/1", redir_cnt, stall_cnt);
    end
  endtask

  task automatic test_pend_override();
    bootReset();
    bj_req = 1'b1; bj_addr = 32'h40;
    iram_gnt = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'b1000_0110) begin
      failed++;
      $display("[TB] FAIL pend_enter got %b want %b", ctl, 8'b1000_0110);
    end
    tick();
    bj_addr = 32'h99;
    #1;
    tests++;
    if (ctl !== 8'b1100_0100 || redirect_addr !== 32'h40) begin
      failed++;
      $display("[TB] FAIL pend_c1 got %b/%h want %b/%h", ctl, redirect_addr, 8'b1100_0100, 32'h40);
    end
    tick();
    bj_req = 1'b0;
    exc_req = 1'b1; exc_addr = 32'h10;
    #1;
    tests++;
    if (ctl !== 8'b1100_0111 || redirect_addr !== 32'h40) begin
      failed++;
      $display("[TB] FAIL pend_c2 got %b/%h want %b/%h", ctl, redirect_addr, 8'b1100_0111, 32'h40);
    end
    tick();
    exc_req = 1'b0;
    #1;
    tests++;
    if (ctl !== 8'b1100_0100 || redirect_addr !== 32'h10 || redir_cnt !== 16'd0) begin
      failed++;
      $display("[TB] FAIL pend_c3 got %b/%h/%0d want %b/%h/0", ctl, redirect_addr, redir_cnt, 8'b1100_0100, 32'h10);
    end
    iram_gnt = 1'b1;
    #1;
    tests++;
    if (redirect_vld !== 1'b1 || redirect_addr !== 32'h10) begin
      failed++;
      $display("[TB] FAIL pend_gnt got %b/%h want 1/%h", redirect_vld, redirect_addr, 32'h10);
    end
    tick();
    tick();
    tests++;
    if (ctl !== 8'b1000_0000 || redir_cnt !== 16'd1 || stall_cnt !== 32'd0) begin
      failed++;
      $display("[TB] FAIL pend_exit got %b/%0d/%0d want %b/1/0", ctl, redir_cnt, stall_cnt, 8'b1000_0000);
    end
  endtask

  task automatic test_load_use();
    bootReset();
    load_use = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b1011_0010) begin
      failed++;
      $display("[TB] FAIL lu got %b want %b", ctl, 8'b1011_0010);
    end
    repeat (3) tick();
    ex_busy = 1'b1;
    #1;
    tests++;
    if (ctl !== 8'b1011_1000 || stall_cnt !== 32'd3) begin
      failed++;
      $display("[TB] FAIL lu_busy got %b/%0d want %b/3", ctl, stall_cnt, 8'b1011_1000);
    end
    tick();
    clearInputs();
    #1;
    tests++;
    if (stall_cnt !== 32'd4) begin
      failed++;
      $display("[TB] FAIL lu_cnt got %0d want 4", stall_cnt);
    end
  endtask

  task automatic test_reset_mid_pend();
    int seen;
    bootReset();
    bj_req = 1'b1; bj_addr = 32'h77;
    iram_gnt = 1'b0;
    tick();
    bj_req = 1'b0;
    #1;
    tests++;
    if (redirect_vld !== 1'b1 || redirect_addr !== 32'h77) begin
      failed++;
      $display("[TB] FAIL rst_pend_pre got %b/%h want 1/%h", redirect_vld, redirect_addr, 32'h77);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (ctl !== 8'b0011_1000 || redirect_addr !== '0) begin
      failed++;
      $display("[TB] FAIL rst_pend got %b/%h want %b/0", ctl, redirect_addr, 8'b0011_1000);
    end
    rst_n = 1'b1;
    iram_gnt = 1'b1;
    seen = 0;
    for (int i = 0; i < BOOT_WAIT + 6; i++) begin
      tick();
      if (redirect_vld !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0 || redir_cnt !== 16'd0) begin
      failed++;
      $display("[TB] FAIL rst_pend_after got %0d/%0d want 0/0", seen, redir_cnt);
    end
  endtask

  task automatic test_random();
    bit          mBooting, mPending, mPendIsExc, take, exStall, expSx, expSid, expSi;
    int          mBootLeft, mRedir;
    longint      mStall;
    logic [31:0] mPendTarget, winTarget, wantAddr;
    logic [7:0]  expCtl;
    bootReset();
    mBooting = 0; mPending = 0; mPendIsExc = 0; mBootLeft = 0;
    mPendTarget = '0; mStall = 0; mRedir = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(99) != 0);
      iram_gnt  = ($urandom_range(3) != 0);
      exc_req   = ($urandom_range(9) == 0);
      mret_req  = ($urandom_range(9) == 0);
      bj_req    = ($urandom_range(5) == 0);
      load_use  = ($urandom_range(5) == 0);
      ex_busy   = ($urandom_range(7) == 0);
      lsu_busy  = ($urandom_range(7) == 0);
      exc_addr  = $urandom;
      mret_addr = $urandom;
      bj_addr   = $urandom;
      #1;
      exStall   = ex_busy | lsu_busy;
      take      = 1'b0;
      winTarget = exc_req ? exc_addr : (mret_req ? mret_addr : bj_addr);
      if (mBooting) begin
        expCtl   = 8'b0011_1000;
        wantAddr = mPendTarget;
      end else if (mPending) begin
        expSx    = (mPendIsExc || exc_req) ? 1'b0 : exStall;
        expCtl   = {1'b1, 1'b1, 1'b0, 1'b0, expSx, 1'b1, exc_req | (load_use & ~expSx), exc_req};
        wantAddr = mPendTarget;
      end else begin
        take     = exc_req | ((mret_req | bj_req) & ~exStall);
        wantAddr = winTarget;
        if (take) begin
          expCtl = {1'b1, iram_gnt, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exc_req};
        end else begin
          expSx  = exStall;
          expSid = exStall | load_use;
          expSi  = expSid | ~iram_gnt;
          expCtl = {1'b1, 1'b0, expSi, expSid, expSx, 1'b0, load_use & ~exStall, 1'b0};
        end
      end
      tests++;
      if (ctl !== expCtl || (expCtl[6] && redirect_addr !== wantAddr)) begin
        failed++;
        $display("[TB] FAIL rand_ctl[%0d] got %b/%h want %b/%h", n, ctl, redirect_addr, expCtl, wantAddr);
      end
      if (!rst_n) begin
        mBooting = 1; mBootLeft = BOOT_WAIT; mPending = 0; mPendIsExc = 0;
        mPendTarget = '0; mStall = 0; mRedir = 0;
      end else if (mBooting) begin
        mBootLeft--;
        if (mBootLeft == 0) mBooting = 0;
      end else if (mPending) begin
        if (exc_req) begin
          mPendTarget = exc_addr;
          mPendIsExc  = 1;
        end else if (iram_gnt) begin
          mPending = 0;
          mRedir   = (mRedir + 1) % 65536;
        end
      end else begin
        if (expCtl[5] && mStall < 64'hFFFF_FFFF) mStall++;
        if (take) begin
          if (iram_gnt) begin
            mRedir = (mRedir + 1) % 65536;
          end else begin
            mPending    = 1;
            mPendTarget = winTarget;
            mPendIsExc  = exc_req;
          end
        end
      end
      tick();
      tests++;
      if (stall_cnt !== mStall[31:0] || redir_cnt !== mRedir[15:0]) begin
        failed++;
        $display("[TB] FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", n, stall_cnt, redir_cnt, mStall, mRedir);
      end
    end
    rst_n = 1'b1;
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_branch();
    test_priority();
    test_pend_override();
    test_load_use();
    test_reset_mid_pend();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
